line_memory_responder: RTL and testbench
========================================

// Module: line_memory_responder
// PURPOSE
//  Multi-cycle line-granular backing memory; responder end of the cache-to-memory request interface.
//  Accepts one read or write per handshake, holds the line for LATENCY cycles, then completes.
//  Sits below the cache controller and serves its write-back and allocate requests.
//  Request and completion handshakes match what the cache FSM drives and samples.
// PARAMETERS
//  BLOCK_SIZE  16     line size in bytes; data ports are BLOCK_SIZE*8 bits
//  NUM_LINES   16384  number of stored lines (power of two)
//  LATENCY     50     cycles from accept to completion (>=1)
// PORTS
//  clk              in   1             rising-edge clock
//  reset            in   1             asynchronous, active-low (0 = in reset)
//  is_input_valid   in   1             request valid
//  addr             in   32            line address (byte address >> CLOG2(BLOCK_SIZE))
//  mem_read         in   1             request is a read
//  mem_write        in   1             request is a write
//  din              in   BLOCK_SIZE*8  write line data
//  is_output_valid  out  1             read data valid on dout (completion cycle only)
//  dout             out  BLOCK_SIZE*8  last completed read line
//  mem_ready        out  1             responder can accept a request this cycle
// BEHAVIOUR
//  - States: S_IDLE, S_BUSY, S_DONE. Reset (reset=0): state S_IDLE, counter 0, dout 0,
//    is_output_valid 0, mem_ready 0 while reset=0; pending op discarded. Array not cleared by reset.
//  - Array initialised to all-zero at time 0.
//  - mem_ready = 1 in S_IDLE and S_DONE, 0 in S_BUSY.
//  - Accept: posedge with is_input_valid & mem_ready -> latch addr, op, din; counter <= LATENCY-1;
//    -> S_BUSY. is_input_valid while mem_ready=0 is ignored (no queueing).
//  - S_BUSY: counter decrements each cycle; at counter==0 the op executes on that edge:
//    write -> array[idx] <= din_latched; read -> dout <= array[idx]; -> S_DONE.
//  - Latency: accept edge T; mem_ready low T..T+LATENCY; S_DONE visible in cycle after edge T+LATENCY.
//  - S_DONE (one cycle): mem_ready=1; is_output_valid=1 only if op was read; dout valid.
//    New request accepted in S_DONE -> S_BUSY directly (back-to-back, required by write-back
//    then allocate); otherwise -> S_IDLE. dout holds until the next read completes.
//  - idx = addr[CLOG2(NUM_LINES)-1:0]; upper bits ignored (addresses wrap modulo NUM_LINES).
//  - mem_read & mem_write both 1: treated as write. Neither set: no-op, still completes after
//    LATENCY with is_output_valid=0.
//  - Counter width CLOG2(LATENCY+1); LATENCY=1 gives BUSY of exactly one cycle.
// CONFIGURATION
//  DMEM_PROTOCOL_CHECK_EN defined: simulation-only checks print an error and $fatal on: request
//    while mem_ready=0, read&write both set, neither set, addr >= NUM_LINES. Datapath unchanged.
//  Not defined: no checks; conditions handled silently as above.
// STRUCTURE
//  Shared package/header: state encodings S_IDLE/S_BUSY/S_DONE; CLOG2 macro (existing CLOG2.v).
//  One sub-module: dmem_line_array (NUM_LINES x BLOCK_SIZE*8 storage, sync write, sync read).
//  FSM, latency counter and request latches stay in this module.
// TESTING (BLOCK_SIZE=16, NUM_LINES=16, LATENCY=4)
//  1. Reset, read addr 5 -> mem_ready 0 for 4 cycles, then 1 cycle is_output_valid=1, dout=128'h0.
//  2. Write addr 3 din=128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, then read 3 -> dout equals din;
//     write completion shows is_output_valid=0.
//  3. Write addr 2, issue read addr 7 in the S_DONE cycle -> accepted, mem_ready 0 next cycle,
//     read completes exactly 4 cycles later; array[2] updated.
//  4. Write addr 3 = 128'h1 after test 2, pull reset low 2 cycles after accept -> outputs at reset
//     values; after release, read 3 returns test-2 data.
//  5. Read addr 19 -> returns array[3] (wrap); with DMEM_PROTOCOL_CHECK_EN build -> $fatal fires.
//  6. Pulse is_input_valid (write addr 9) while S_BUSY -> ignored; later read 9 returns 128'h0.

Source files
------------

// File: rtl/line_memory_responder_pkg.sv
// rtl/line_memory_responder_pkg.sv - shared state encoding and width helper for the line memory responder
package line_memory_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - line storage, synchronous write and registered synchronous read
module dmem_line_array #(
    parameter int DATA_W    = 128,
    parameter int NUM_LINES = 16384,
    parameter int IDX_W     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [DATA_W-1:0] lines [NUM_LINES] = '{default: '0};

    always @(posedge clk) begin
        if (wr_en) begin
            lines[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= lines[idx];
        end
    end

endmodule

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - multi-cycle line memory responder; optional checks under DMEM_PROTOCOL_CHECK_EN
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 16384,
    parameter int LATENCY    = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int DATA_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = clog2(NUM_LINES);
    localparam int CNT_W  = clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [IDX_W-1:0]    idx_q;
    logic                op_read_q;
    logic                op_write_q;
    logic [DATA_W-1:0]   din_q;
    logic                accept;
    logic                execute;
    logic                unused_addr_hi;

    assign mem_ready      = reset & (state != S_BUSY);
    assign accept         = is_input_valid & mem_ready;
    assign execute        = (state == S_BUSY) && (counter == '0);
    assign unused_addr_hi = ^addr[31:IDX_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            counter         <= '0;
            idx_q           <= '0;
            op_read_q       <= 1'b0;
            op_write_q      <= 1'b0;
            din_q           <= '0;
            is_output_valid <= 1'b0;
        end else begin
            is_output_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        // Write wins when both op bits are set.
                        idx_q      <= addr[IDX_W-1:0];
                        op_write_q <= mem_write;
                        op_read_q  <= mem_read & ~mem_write;
                        din_q      <= din;
                        counter    <= CNT_LOAD;
                        state      <= S_BUSY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (counter == '0) begin
                        is_output_valid <= op_read_q;
                        state           <= S_DONE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    dmem_line_array #(
        .DATA_W   (DATA_W),
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (execute & op_write_q),
        .rd_en  (execute & op_read_q),
        .idx    (idx_q),
        .wr_data(din_q),
        .rd_data(dout)
    );

`ifdef DMEM_PROTOCOL_CHECK_EN
    always @(posedge clk) begin
        if (reset && is_input_valid) begin
            if (!mem_ready)
                $fatal(1, "dmem: request while mem_ready=0");
            else if (mem_read && mem_write)
                $fatal(1, "dmem: read and write both set");
            else if (!mem_read && !mem_write)
                $fatal(1, "dmem: neither read nor write set");
            else if (addr >= 32'(NUM_LINES))
                $fatal(1, "dmem: addr %0d out of range", addr);
        end
    end
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - self-checking bench for line_memory_responder
module tb_line_memory_responder;

    localparam int BS  = 16;
    localparam int NL  = 16;
    localparam int LAT = 4;
    localparam int DW  = BS * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_input_valid;
    logic [31:0]   addr;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] din;
    logic          is_output_valid;
    logic [DW-1:0] dout;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [NL];
    logic [DW-1:0] ref_dout;

    typedef struct {
        logic [31:0]   a;
        logic          r;
        logic          w;
        logic [DW-1:0] d;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl [8];

    localparam logic [DW-1:0] PAT_D = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [DW-1:0] PAT_A = 128'h5555_AAAA_1234_5678_9ABC_DEF0_CAFE_F00D;
    localparam logic [DW-1:0] PAT_X = 128'h0BAD_C0DE_7777_8888_9999_AAAA_BBBB_CCCC;

    line_memory_responder #(
        .BLOCK_SIZE(BS),
        .NUM_LINES (NL),
        .LATENCY   (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .din            (din),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: line index is the address modulo the line count; write beats read.
    task automatic model(input logic [31:0] a, input logic r, input logic w, input logic [DW-1:0] d,
                         output logic ev, output logic [DW-1:0] ed);
        int i;
        i = int'(a % NL);
        ev = 1'b0;
        if (w) begin
            ref_mem[i] = d;
        end else if (r) begin
            ref_dout = ref_mem[i];
            ev = 1'b1;
        end
        ed = ref_dout;
    endtask

    // Called at a negedge; returns at the negedge that shows the completion cycle.
    task automatic run_req(input logic [31:0] a, input logic r, input logic w, input logic [DW-1:0] d,
                           input logic ev, input logic [DW-1:0] ed);
        chk("ready_before_req", {127'b0, mem_ready}, 1);
        addr = a; mem_read = r; mem_write = w; din = d; is_input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        is_input_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            chk("busy_ready_low", {127'b0, mem_ready}, 0);
            @(negedge clk);
        end
        chk("done_ready", {127'b0, mem_ready}, 1);
        chk("done_valid", {127'b0, is_output_valid}, {127'b0, ev});
        chk("done_dout", dout, ed);
    endtask

    task automatic do_req(input logic [31:0] a, input logic r, input logic w, input logic [DW-1:0] d);
        logic          ev;
        logic [DW-1:0] ed;
        model(a, r, w, d, ev, ed);
        run_req(a, r, w, d, ev, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          ev;
        logic [DW-1:0] ed;
        int            n;

        for (int i = 0; i < NL; i++) ref_mem[i] = '0;
        ref_dout = '0;

        tbl[0] = '{a: 32'd5,  r: 1'b1, w: 1'b0, d: '0,    ev: 1'b1, ed: '0};
        tbl[1] = '{a: 32'd3,  r: 1'b0, w: 1'b1, d: PAT_D, ev: 1'b0, ed: '0};
        tbl[2] = '{a: 32'd3,  r: 1'b1, w: 1'b0, d: '0,    ev: 1'b1, ed: PAT_D};
        tbl[3] = '{a: 32'd19, r: 1'b1, w: 1'b0, d: '0,    ev: 1'b1, ed: PAT_D};
        tbl[4] = '{a: 32'd4,  r: 1'b0, w: 1'b0, d: PAT_X, ev: 1'b0, ed: PAT_D};
        tbl[5] = '{a: 32'd4,  r: 1'b1, w: 1'b1, d: PAT_A, ev: 1'b0, ed: PAT_D};
        tbl[6] = '{a: 32'd4,  r: 1'b1, w: 1'b0, d: '0,    ev: 1'b1, ed: PAT_A};
        tbl[7] = '{a: 32'd20, r: 1'b1, w: 1'b0, d: '0,    ev: 1'b1, ed: PAT_A};

        reset = 1'b0; is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0; din = '0;
        #1;
        chk("reset_ready", {127'b0, mem_ready}, 0);
        chk("reset_valid", {127'b0, is_output_valid}, 0);
        chk("reset_dout", dout, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            model(tbl[k].a, tbl[k].r, tbl[k].w, tbl[k].d, ev, ed);
            run_req(tbl[k].a, tbl[k].r, tbl[k].w, tbl[k].d, tbl[k].ev, tbl[k].ed);
            if (k % 2 == 1) @(negedge clk);
        end
        @(negedge clk);

        // Back-to-back: read issued in the write's completion cycle.
        do_req(32'd2, 1'b0, 1'b1, PAT_X);
        do_req(32'd7, 1'b1, 1'b0, '0);
        @(negedge clk);
        do_req(32'd2, 1'b1, 1'b0, '0);
        @(negedge clk);

        // Reset two cycles into a write: the write must be dropped.
        addr = 32'd3; mem_read = 1'b0; mem_write = 1'b1; din = 128'h1; is_input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        is_input_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midop_reset_ready", {127'b0, mem_ready}, 0);
        chk("midop_reset_valid", {127'b0, is_output_valid}, 0);
        chk("midop_reset_dout", dout, '0);
        ref_dout = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(32'd3, 1'b1, 1'b0, '0);
        chk("reset_keeps_array", dout, PAT_D);
        @(negedge clk);

        // Request pulsed while busy must be ignored.
        model(32'd0, 1'b1, 1'b0, '0, ev, ed);
        addr = 32'd0; mem_read = 1'b1; mem_write = 1'b0; din = '0; is_input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = 32'd9; mem_read = 1'b0; mem_write = 1'b1; din = '1;
        @(posedge clk);
        @(negedge clk);
        is_input_valid = 1'b0;
        n = 0;
        while (!mem_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_pulse_done_ready", {127'b0, mem_ready}, 1);
        chk("busy_pulse_done_valid", {127'b0, is_output_valid}, {127'b0, ev});
        chk("busy_pulse_done_dout", dout, ed);
        @(negedge clk);
        model(32'd9, 1'b1, 1'b0, '0, ev, ed);
        run_req(32'd9, 1'b1, 1'b0, '0, 1'b1, '0);
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            logic [31:0]   ra;
            logic          rr;
            logic          rw;
            logic [DW-1:0] rd;
            ra = $urandom;
            rr = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rd = {$urandom, $urandom, $urandom, $urandom};
            do_req(ra, rr, rw, rd);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
